// File: rtl/button_event_controller_pkg.sv
// Shared constants for the button event controller: play-mode codes,
// default timing values and a small mode-decoding helper.
package button_event_controller_pkg;

    // Play-mode codes carried on the 3-bit mode input.
    typedef enum logic [2:0] {
        MODEMANUAL = 3'b001,
        MODEAUTO   = 3'b011,
        MODELRN    = 3'b111
    } mode_e;

    // Default debounce gap and auto-repeat period, in clock cycles.
    localparam logic [24:0] DEF_GAP    = 25'd20_000_000;
    localparam logic [24:0] DEF_REPEAT = 25'd10_000_000;

    // Song navigation is live only in auto and learning modes.
    function automatic logic is_nav_mode(input logic [2:0] mode);
        return (mode == MODEAUTO) || (mode == MODELRN);
    endfunction

endpackage

// File: rtl/button_event_controller_if.sv
// Bundle of the controller's functional signals. The master side drives
// play mode and raw buttons; the slave side (the controller) returns
// press events, the pause state and the selected song.
interface button_event_controller_if #(
    parameter int unsigned N_BTN    = 3,
    parameter int unsigned SONG_CNT = 4
);
    localparam int unsigned SW = $clog2(SONG_CNT);

    logic [2:0]       mode;
    logic [N_BTN-1:0] button;
    logic [N_BTN-1:0] btn_evt;
    logic             pause;
    logic [SW-1:0]    song_num;

    modport master (
        output mode,
        output button,
        input  btn_evt,
        input  pause,
        input  song_num
    );

    modport slave (
        input  mode,
        input  button,
        output btn_evt,
        output pause,
        output song_num
    );

endinterface

// File: rtl/button_debounce.sv
// Per-button hold counter and one-cycle press pulse.
// A press is accepted on the GAP-th consecutive high sample. With the
// BTN_REPEAT_EN macro defined, a held button re-fires every REPEAT cycles;
// otherwise the counter saturates at GAP and fires once per press.
module button_debounce
    import button_event_controller_pkg::*;
#(
    parameter int unsigned GAP    = DEF_GAP,
    parameter int unsigned REPEAT = DEF_REPEAT
)(
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic evt_next,   // pulse value that will be registered on this edge
    output logic evt         // registered one-cycle press pulse
);
    localparam int unsigned CW = $clog2(GAP + REPEAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next counter value and whether this edge completes a press.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        cnt_d    = cnt_q;
        evt_next = 1'b0;
        if (!button) begin
            cnt_d = '0;
        end else begin
            if (cnt_q == CW'(GAP - 1)) begin
                evt_next = 1'b1;
            end
`ifdef BTN_REPEAT_EN
            // Reaching GAP+REPEAT reloads to GAP and counts as a fresh press.
            if (cnt_q == CW'(GAP + REPEAT - 1)) begin
                cnt_d    = CW'(GAP);
                evt_next = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
`else
            // Saturate at GAP so a long hold yields a single event.
            if (cnt_q != CW'(GAP)) begin
                cnt_d = cnt_q + CW'(1);
            end
`endif
        end
    end

    // Hold counter and registered event pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
            evt   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt   <= evt_next;
        end
    end

endmodule

// File: rtl/button_event_controller.sv
// Button event controller: debounces N_BTN push-buttons and turns accepted
// presses into song navigation (prev/next, modulo SONG_CNT) and a
// play/pause toggle, gated by the play mode.
// Optional feature: define BTN_REPEAT_EN for auto-repeat on held buttons.
module button_event_controller
    import button_event_controller_pkg::*;
#(
    parameter int unsigned N_BTN     = 3,
    parameter int unsigned GAP       = DEF_GAP,
    parameter int unsigned SONG_CNT  = 4,
    parameter int unsigned BTN_PREV  = 0,
    parameter int unsigned BTN_PAUSE = 1,
    parameter int unsigned BTN_NEXT  = 2,
    parameter int unsigned REPEAT    = DEF_REPEAT
)(
    input logic clk,
    input logic rst,
    button_event_controller_if.slave bus
);
    localparam int unsigned SW = $clog2(SONG_CNT);
    localparam logic [SW-1:0] SONG_LAST = SW'(SONG_CNT - 1);

    logic [N_BTN-1:0] evt_next;
    logic [N_BTN-1:0] evt_q;
    logic [SW-1:0]    song_q;
    logic [SW-1:0]    song_d;
    logic             pause_q;
    logic             pause_d;
    logic             prev_hit;
    logic             next_hit;
    logic             pause_hit;

    // One debouncer per button; the unregistered pulse lets song/pause
    // change on the same edge the registered event goes high.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_debounce #(
            .GAP    (GAP),
            .REPEAT (REPEAT)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .button   (bus.button[i]),
            .evt_next (evt_next[i]),
            .evt      (evt_q[i])
        );
    end

    assign prev_hit  = evt_next[BTN_PREV];
    assign next_hit  = evt_next[BTN_NEXT];
    assign pause_hit = evt_next[BTN_PAUSE];

    // Next song index and pause state from this edge's events and the mode.
    always_comb begin
        song_d  = song_q;
        pause_d = pause_q;

        if (is_nav_mode(bus.mode)) begin
            // Simultaneous prev and next cancel out.
            if (prev_hit && !next_hit) begin
                song_d = (song_q == '0) ? SONG_LAST : song_q - SW'(1);
            end else if (next_hit && !prev_hit) begin
                song_d = (song_q == SONG_LAST) ? '0 : song_q + SW'(1);
            end
        end else begin
            song_d = '0;
        end

        if (bus.mode == MODEAUTO) begin
            if (pause_hit) begin
                pause_d = ~pause_q;
            end
        end else begin
            pause_d = 1'b0;
        end
    end

    // Song index and pause state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            song_q  <= '0;
            pause_q <= 1'b0;
        end else begin
            song_q  <= song_d;
            pause_q <= pause_d;
        end
    end

    assign bus.btn_evt  = evt_q;
    assign bus.song_num = song_q;
    assign bus.pause    = pause_q;

endmodule

// File: tb/tb_button_event_controller.sv
// Directed self-checking bench for button_event_controller with GAP=4,
// REPEAT=3, SONG_CNT=3. Expectations follow BTN_REPEAT_EN when defined.
module tb_button_event_controller;
    import button_event_controller_pkg::*;

    localparam int unsigned N_BTN = 3;
    localparam int unsigned SONGS = 3;

    localparam logic [2:0] B_PREV  = 3'b001;
    localparam logic [2:0] B_PAUSE = 3'b010;
    localparam logic [2:0] B_NEXT  = 3'b100;

`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   s_exp;
    logic ev_exp;

    button_event_controller_if #(.N_BTN(N_BTN), .SONG_CNT(SONGS)) bus ();

    button_event_controller #(
        .N_BTN     (N_BTN),
        .GAP       (4),
        .SONG_CNT  (SONGS),
        .BTN_PREV  (0),
        .BTN_PAUSE (1),
        .BTN_NEXT  (2),
        .REPEAT    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] evt,
                             input int song, input logic pause);
        check({tag, ".evt"},   32'(bus.btn_evt),  32'(evt));
        check({tag, ".song"},  32'(bus.song_num), 32'(song));
        check({tag, ".pause"}, 32'(bus.pause),    32'(pause));
    endtask

    // Full 4-cycle press: no event for three edges, one on the fourth,
    // then release.
    task automatic press(input string tag, input logic [2:0] mask,
                         input int song, input logic pause);
        bus.button = mask;
        repeat (3) begin
            tick();
            check({tag, ".early_evt"}, 32'(bus.btn_evt), 32'd0);
        end
        tick();
        check_all({tag, ".edge4"}, mask, song, pause);
        bus.button = '0;
        tick();
        check_all({tag, ".release"}, 3'b000, song, pause);
    endtask

    initial begin
        bus.mode   = MODEAUTO;
        bus.button = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check_all("reset", 3'b000, 0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all("post_reset", 3'b000, 0, 1'b0);

        // NEXT held 4 cycles: event and song change together on edge 4
        bus.button = B_NEXT;
        repeat (3) tick();
        check_all("next4.edge3", 3'b000, 0, 1'b0);
        tick();
        check_all("next4.edge4", B_NEXT, 1, 1'b0);
        tick();
        check_all("next4.edge5_held", 3'b000, 1, 1'b0);
        bus.button = '0;
        tick();
        check_all("next4.release", 3'b000, 1, 1'b0);

        // NEXT held only 3 cycles: nothing happens
        bus.button = B_NEXT;
        repeat (3) begin
            tick();
            check("short.evt", 32'(bus.btn_evt), 32'd0);
        end
        bus.button = '0;
        tick();
        check_all("short.release", 3'b000, 1, 1'b0);

        // Wrap-around in both directions
        press("prev_1to0",  B_PREV, 0, 1'b0);
        press("prev_wrap",  B_PREV, 2, 1'b0);
        press("next_wrap",  B_NEXT, 0, 1'b0);

        // PREV and NEXT together cancel
        press("both", B_PREV | B_NEXT, 0, 1'b0);

        // Pause toggling in auto mode, then set up song 2 / pause 1
        press("pause_on",  B_PAUSE, 0, 1'b1);
        press("pause_off", B_PAUSE, 0, 1'b0);
        press("pause_on2", B_PAUSE, 0, 1'b1);
        press("next_0to1", B_NEXT,  1, 1'b1);
        press("next_1to2", B_NEXT,  2, 1'b1);

        // Manual mode forces song and pause to 0 on the next edge
        bus.mode = MODEMANUAL;
        tick();
        check_all("manual.force", 3'b000, 0, 1'b0);
        press("manual_next",  B_NEXT,  0, 1'b0);
        press("manual_pause", B_PAUSE, 0, 1'b0);

        // Learning mode: navigation works, pause stays 0
        bus.mode = MODELRN;
        press("lrn_next",  B_NEXT,  1, 1'b0);
        press("lrn_pause", B_PAUSE, 1, 1'b0);
        press("lrn_prev",  B_PREV,  0, 1'b0);

        // Mode change mid-hold: exactly one event, on the 4th sample
        bus.button = B_NEXT;
        tick();
        tick();
        check("modechg.edge2", 32'(bus.btn_evt), 32'd0);
        bus.mode = MODEAUTO;
        tick();
        check("modechg.edge3", 32'(bus.btn_evt), 32'd0);
        tick();
        check_all("modechg.edge4", B_NEXT, 1, 1'b0);
        tick();
        check("modechg.edge5", 32'(bus.btn_evt), 32'd0);
        bus.button = '0;
        tick();

        // Long hold from song 0: repeats only with BTN_REPEAT_EN
        press("prev_to0", B_PREV, 0, 1'b0);
        s_exp = 0;
        bus.button = B_NEXT;
        for (int e = 1; e <= 12; e++) begin
            tick();
            ev_exp = (e == 4) || (REP_EN && (e == 7 || e == 10));
            if (ev_exp) s_exp = (s_exp + 1) % SONGS;
            check_all($sformatf("hold12.e%0d", e), ev_exp ? B_NEXT : 3'b000, s_exp, 1'b0);
        end
        bus.button = '0;
        tick();
        check("hold12.final_song", 32'(bus.song_num), 32'(REP_EN ? 0 : 1));

        // Set up song 2, pause 1 for the reset test
        press("pause_set", B_PAUSE, s_exp, 1'b1);
        for (int k = 0; k < 2 && s_exp != 2; k++) begin
            s_exp = (s_exp + SONGS - 1) % SONGS;
            press("prev_setup", B_PREV, s_exp, 1'b1);
        end
        check_all("pre_reset", 3'b000, 2, 1'b1);

        // Asynchronous reset mid-hold, between clock edges
        bus.button = B_NEXT;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 3'b000, 0, 1'b0);
        tick();
        tick();
        check_all("rst_held", 3'b000, 0, 1'b0);

        // Button still held across release: first event GAP samples later
        #3 rst = 1'b0;
        repeat (3) begin
            tick();
            check_all("after_rst.early", 3'b000, 0, 1'b0);
        end
        tick();
        check_all("after_rst.edge4", B_NEXT, 1, 1'b0);
        bus.button = '0;
        tick();
        check_all("after_rst.release", 3'b000, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_event_controller.md
BUTTON_EVENT_CONTROLLER -- requirements
Module: button_event_controller

Interface
REQ-001 SHALL have parameter N_BTN, default 3, number of push-buttons.
REQ-002 SHALL have parameter GAP, default 25'd20_000_000, consecutive high samples per accepted press (GAP >= 2).
REQ-003 SHALL have parameter SONG_CNT, default 4, number of selectable songs (2..256, not necessarily power of two).
REQ-004 SHALL have parameters BTN_PREV/BTN_PAUSE/BTN_NEXT, defaults 0/1/2, button index per function.
REQ-005 SHALL have parameter REPEAT, default 25'd10_000_000, auto-repeat period in cycles (used only with BTN_REPEAT_EN).
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 mode  input  3  play mode: 3'b011 auto, 3'b001 manual, 3'b111 learning.
REQ-009 button  input  N_BTN  raw active-high buttons, already synchronised.
REQ-010 btn_evt  output  N_BTN  one-cycle press-event pulse per button.
REQ-011 pause  output  1  play/pause toggle state.
REQ-012 song_num  output  $clog2(SONG_CNT)  selected song index.

Function
REQ-013 Per button, a hold counter (width $clog2(GAP+REPEAT+1)) SHALL increment each cycle the button is high and clear to 0 the cycle it is low.
REQ-014 btn_evt[i] SHALL be high for exactly one cycle, registered, on the edge where counter i goes GAP-1 -> GAP (GAP-th consecutive high sample); counter SHALL saturate at GAP without BTN_REPEAT_EN.
REQ-015 Debounce counters and btn_evt SHALL operate in every mode.
REQ-016 In auto or learning mode: PREV event SHALL decrement song_num, NEXT event increment, same edge as the event pulse, modulo SONG_CNT (0-1 -> SONG_CNT-1, SONG_CNT-1+1 -> 0).
REQ-017 PREV and NEXT events on the same edge SHALL leave song_num unchanged.
REQ-018 In any other mode song_num SHALL be forced to 0 on the next edge.
REQ-019 In auto mode a PAUSE event SHALL toggle pause on the same edge; in any other mode pause SHALL be forced to 0.
REQ-020 Mode change while a button is held SHALL NOT generate an extra event; counters continue unaffected.
REQ-021 Release before GAP samples SHALL produce no event and no output change.

Reset
REQ-022 rst high SHALL asynchronously set all hold counters, btn_evt, pause and song_num to 0.
REQ-023 A button held across reset release SHALL count from 0 and produce its first event GAP samples after release.

Configuration
REQ-024 With BTN_REPEAT_EN defined, a held button SHALL produce further events every REPEAT cycles after the first (counter reaching GAP+REPEAT reloads to GAP and pulses), each acting as a fresh press.
REQ-025 Without BTN_REPEAT_EN, one event per press SHALL be produced regardless of hold time and REPEAT SHALL be unused.

Structure
REQ-026 Mode codes (MODEAUTO, MODEMANUAL, MODELRN) and default GAP/REPEAT SHALL live in the shared constants include, not locally.
REQ-027 Per-button counter/pulse logic SHALL be one sub-module, button_debounce, instantiated N_BTN times via generate.

Verification (GAP=4, REPEAT=3, SONG_CNT=3)
REQ-028 mode=011, button[2] high 4 cycles -> btn_evt[2] one pulse on 4th edge, song_num 0->1; 3 cycles -> no change.
REQ-029 mode=011, song_num=0, PREV press -> song_num=2; from 2, NEXT press -> 0.
REQ-030 mode=011, PREV and NEXT pressed same cycle for 4 cycles -> both btn_evt pulse, song_num unchanged.
REQ-031 mode=011 PAUSE press -> pause=1; second press -> 0; switch mode to 001 -> pause=0, song_num=0 next edge.
REQ-032 BTN_REPEAT_EN, NEXT held 12 cycles from song 0 -> events on edges 4, 7, 10, song_num 1,2,0; without macro -> single event, song_num=1.
REQ-033 rst asserted mid-hold with song_num=2, pause=1 -> all outputs 0 immediately, no clock required.
